// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key map, idle row drive.
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan,
    StDebPress,
    StHeld,
    StDebRelease
  } kp_state_t;

  localparam logic [3:0] ROW_IDLE = 4'b1110;

  // Entry (row*4 + col) lives at bits [4*(row*4+col) +: 4].
  localparam logic [63:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[{row, col, 2'b00} +: 4];
  endfunction

  // Keep only the lowest-index low bit; all-ones means no key.
  function automatic logic [3:0] lowest_low(input logic [3:0] cols);
    logic [3:0] inv;
    inv = ~cols;
    return ~(inv & (~inv + 4'd1));
  endfunction

  function automatic logic [1:0] pat_to_col(input logic [3:0] pat);
    logic [1:0] col;
    col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!pat[i]) col = 2'(i);
    end
    return col;
  endfunction

endpackage

// File: rtl/keypad_scan_debounce_sync2.sv
// Parameterized-width two-flop synchronizer; synchronous reset to all-ones (idle pulled-up lines).
module sync2 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad row scanner with press/release debounce and one-cycle key strobe.
// Define KEYPAD_MULTIKEY_REJECT_EN to treat several low columns as no key.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 24000,
  parameter int unsigned DEBOUNCE_CYCLES = 480000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] columns,
  output logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_CYCLES);

  logic [3:0]      col_s;
  logic [3:0]      col_res;
  logic            key_found;
  logic            advance;
  logic [CntW-1:0] cnt_inc;

  kp_state_t       state_q, state_d;
  logic [1:0]      row_q, row_d;
  logic [3:0]      rows_q, rows_d;
  logic [DivW-1:0] div_q, div_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      pat_q, pat_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;

  sync2 #(
    .WIDTH(4)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (columns),
    .q    (col_s)
  );

`ifdef KEYPAD_MULTIKEY_REJECT_EN
  assign col_res = ($countones(~col_s) == 1) ? col_s : 4'b1111;
`else
  assign col_res = lowest_low(col_s);
`endif

  assign key_found = (col_res != 4'b1111);
  assign cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    rows_d      = rows_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    pat_d       = pat_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    advance     = 1'b0;

    unique case (state_q)
      StScan: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (key_found) begin
            pat_d   = col_res;
            cnt_d   = '0;
            state_d = StDebPress;
          end else begin
            advance = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StDebPress: begin
        if (col_res == pat_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntMax) begin
            key_code_d  = key_lookup(row_q, pat_to_col(pat_q));
            key_valid_d = 1'b1;
            state_d     = StHeld;
          end
        end else begin
          cnt_d   = '0;
          state_d = StScan;
          advance = 1'b1;
        end
      end
      StHeld: begin
        if (col_s == 4'b1111) begin
          cnt_d   = '0;
          state_d = StDebRelease;
        end
      end
      StDebRelease: begin
        if (col_s == 4'b1111) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntMax) begin
            cnt_d   = '0;
            state_d = StScan;
            advance = 1'b1;
          end
        end else begin
          state_d = StHeld;
        end
      end
      default: state_d = StScan;
    endcase

    // Leaving a row always restarts the dwell on the next row.
    if (advance) begin
      row_d  = row_q + 2'd1;
      rows_d = {rows_q[2:0], rows_q[3]};
      div_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StScan;
      row_q       <= 2'd0;
      rows_q      <= ROW_IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      pat_q       <= 4'b1111;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      rows_q      <= rows_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign rows      = rows_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule

// File: doc/keypad_scan_debounce.md
# keypad_scan_debounce

Scans a 4x4 matrix keypad by driving one row low at a time, synchronizes the active-low column inputs, and debounces both the press and the release. It emits a single-cycle `key_valid` strobe with a 4-bit hex `key_code` for each accepted key press. It sits between the keypad pins and the digit-history/seven-segment display path, which shifts in the new code on each strobe.

## Interface
- `SCAN_DIV`, 24000: clock cycles each row is held low while scanning (1 ms at 24 MHz); must be ≥ 4.
- `DEBOUNCE_CYCLES`, 480000: consecutive stable cycles required to accept a press or a release (20 ms); must be ≥ 1.
- `clk` in 1: system clock from HSOSC.
- `reset` in 1: synchronous, active-high.
- `columns` in 4: raw keypad columns, active-low, pulled up, asynchronous.
- `rows` out 4: row drive, active-low one-hot.
- `key_code` out 4: hex value of the last accepted key; holds until the next accept.
- `key_valid` out 1: one-cycle pulse when `key_code` updates.

## Operation
- Columns pass through a two-flop synchronizer (`col_s`); all logic uses `col_s` only.
- Key map, indexed [row][col]:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
- States: SCAN, DEB_PRESS, HELD, DEB_RELEASE.
- SCAN:
  - Row index advances 0→1→2→3→0 every `SCAN_DIV` cycles.
  - `col_s` is evaluated only on the last cycle of each dwell.
  - If any bit is low, latch the row and column pattern, clear the counter, and go to DEB_PRESS. `rows` stays frozen on the latched row.
- DEB_PRESS:
  - Counter increments each cycle `col_s` equals the latched pattern.
  - Any mismatch returns to SCAN at the next row.
  - When the count reaches `DEBOUNCE_CYCLES`, register `key_code` and pulse `key_valid`, then go to HELD.
- HELD:
  - `rows` stays frozen; no strobes are produced.
  - When `col_s` == 4'b1111, clear the counter and go to DEB_RELEASE.
- DEB_RELEASE:
  - Counter increments while `col_s` == 4'b1111.
  - Any low bit returns to HELD; no new strobe is produced.
  - When the count reaches `DEBOUNCE_CYCLES`, go to SCAN and resume at the row after the latched row.
- Multiple low columns: handled per Configuration.
- A second key on another row while HELD is invisible, since that row is not driven, and is ignored.

## Timing
- Reset values:
  - `rows` = 4'b1110
  - `key_code` = 4'h0, `key_valid` = 0
  - state = SCAN, all counters 0, synchronizer flops 4'b1111
- Reset mid-operation aborts any debounce with no strobe, and behaviour matches the reset values above.
- Synchronizer latency is 2 cycles. `SCAN_DIV` ≥ 4 guarantees `col_s` reflects the current row at the evaluation cycle.
- Press-to-strobe latency is at most 2 + 4·`SCAN_DIV` + `DEBOUNCE_CYCLES` + 1 cycles after the press is stable.
- `key_valid` is high for exactly one cycle. `key_code` changes on that same edge.
- Counters saturate at `DEBOUNCE_CYCLES` and never wrap.
- Scan divider width is $clog2(`SCAN_DIV`).
- Debounce counter width is $clog2(`DEBOUNCE_CYCLES`+1).

## Configuration
- `KEYPAD_MULTIKEY_REJECT_EN`:
  - Defined: a `col_s` pattern with more than one low bit is treated as no key in SCAN. In DEB_PRESS it counts as a mismatch, so the block returns to SCAN with no strobe.
  - Undefined: the lowest-index low column wins, and the latched pattern is that single bit.

## Structure
- Package `keypad_pkg` holds:
  - the state enum `kp_state_t`
  - the 16-entry key-map constant `KEY_MAP`
  - the reset constant `ROW_IDLE` = 4'b1110
- Sub-module `sync2`: parameterized-width two-flop synchronizer with synchronous reset to all-ones.
- Everything else (FSM, scan divider, debounce counter) stays in `keypad_scan_debounce`.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEBOUNCE_CYCLES`=8.
- Clean press: hold row1/col1 low for 60 cycles, then release → exactly one `key_valid` pulse with `key_code`=4'h5. `rows` frozen at 4'b1101 until the release debounce completes.
- Press bounce: col2 low on row0 for 5 cycles, high for 2, low for 30 → no strobe from the first burst, then one strobe with `key_code`=4'h3.
- Release bounce: hold row3/col1 (code 0), then release with 3-cycle glitches back to low → still only one strobe. State returns to HELD on each glitch. SCAN resumes only after 8 clean idle cycles.
- Ignored key: while HELD on key 'A' (row0/col3), press row2/col0 → no strobe. After 'A' is released and debounced, the block strobes 4'h7.
- Reset mid-operation: assert `reset` during DEB_PRESS → no strobe, `rows`=4'b1110 and `key_code`=4'h0 on the next cycle.
- Multikey: cols 0 and 2 low on row2 → with the macro defined, no strobe; undefined, a strobe with `key_code`=4'h7.
